// File: rtl/cache_ctrl_pkg.sv
// Shared types and tree-PLRU helpers for the cache route decider.
//   state_e      : decider FSM states
//   route_e      : route encoding (hit / clean miss / dirty miss)
//   plru_victim  : 3-bit tree state -> victim way
//   plru_touch   : 3-bit tree state + used way -> updated tree state
package cache_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SETUP     = 2'd1,
    ST_DRIVE     = 2'd2,
    ST_WAIT_FREE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ROUTE_HIT   = 2'd0,
    ROUTE_CLEAN = 2'd1,
    ROUTE_DIRTY = 2'd2
  } route_e;

  // bits = {b2,b1,b0}; b0 picks the pair, b1/b2 pick within the pair
  function automatic logic [1:0] plru_victim(input logic [2:0] bits);
    logic [1:0] way;
    if (!bits[0]) way = bits[1] ? 2'd1 : 2'd0;
    else          way = bits[2] ? 2'd3 : 2'd2;
    return way;
  endfunction

  // Point the tree away from the way just used
  function automatic logic [2:0] plru_touch(input logic [2:0] bits,
                                            input logic [1:0] way);
    logic [2:0] r;
    r = bits;
    case (way)
      2'd0: begin r[0] = 1'b1; r[1] = 1'b1; end
      2'd1: begin r[0] = 1'b1; r[1] = 1'b0; end
      2'd2: begin r[0] = 1'b0; r[2] = 1'b1; end
      default: begin r[0] = 1'b0; r[2] = 1'b0; end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer followed by a registered rising-edge detector.
//   clk     : sampling clock
//   rst     : synchronous active-high reset (clears all flops)
//   d_async : asynchronous input
//   rise    : one-cycle pulse, SYNC_STAGES+1 edges after d_async rises
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   last_q, last_d;
  logic                   rise_q, rise_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_async};
    last_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~last_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      last_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
      rise_q <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/cache_route_decider.sv
// Decision stage in front of the 3-way cache selector. Captures one cache
// lookup result, picks a route and victim from per-set tree-PLRU state,
// launches the selector with a single o_drive pulse, then waits for the
// selector's i_free before touching PLRU and accepting the next request.
//   clk, rst                : clock, synchronous active-high reset
//   req_valid / req_ready   : request handshake (ready only in IDLE)
//   req_set/hit/hit_way/dirty : captured lookup result
//   valid0/1/2              : one-hot route hit / clean miss / dirty miss
//   o_victim_way            : hit way on hit, PLRU victim on miss
//   o_drive                 : one-cycle launch pulse
//   i_free                  : asynchronous completion, rising edge counts
//   o_busy                  : not IDLE
//   o_spurious              : sticky, i_free edge seen outside WAIT_FREE
module cache_route_decider
  import cache_ctrl_pkg::*;
#(
  parameter int SETS        = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [$clog2(SETS)-1:0] req_set,
  input  logic                    req_hit,
  input  logic [1:0]              req_hit_way,
  input  logic [3:0]              req_dirty,
  output logic                    valid0,
  output logic                    valid1,
  output logic                    valid2,
  output logic [1:0]              o_victim_way,
  output logic                    o_drive,
  input  logic                    i_free,
  output logic                    o_busy,
  output logic                    o_spurious
);

  localparam int SET_W = $clog2(SETS);

  state_e                 state_q, state_d;
  logic [SET_W-1:0]       set_q, set_d;
  logic                   hit_q, hit_d;
  logic [1:0]             hit_way_q, hit_way_d;
  logic [3:0]             dirty_q, dirty_d;
  logic [2:0]             valid_q, valid_d;     // {valid2,valid1,valid0}
  logic [1:0]             victim_q, victim_d;
  logic                   drive_q, drive_d;
  logic                   spurious_q, spurious_d;
  logic [SETS-1:0][2:0]   plru_q, plru_d;

  logic                   free_rise;
  logic [1:0]             sel_way;
  route_e                 sel_route;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_free_sync (
    .clk     (clk),
    .rst     (rst),
    .d_async (i_free),
    .rise    (free_rise)
  );

  // Route/victim for the captured request, from the current PLRU of its set
  always_comb begin
    sel_way   = hit_q ? hit_way_q : plru_victim(plru_q[set_q]);
    sel_route = hit_q          ? ROUTE_HIT :
                dirty_q[sel_way] ? ROUTE_DIRTY : ROUTE_CLEAN;
  end

  // State register and datapath flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      set_q      <= '0;
      hit_q      <= 1'b0;
      hit_way_q  <= '0;
      dirty_q    <= '0;
      valid_q    <= '0;
      victim_q   <= '0;
      drive_q    <= 1'b0;
      spurious_q <= 1'b0;
      plru_q     <= '0;
    end else begin
      state_q    <= state_d;
      set_q      <= set_d;
      hit_q      <= hit_d;
      hit_way_q  <= hit_way_d;
      dirty_q    <= dirty_d;
      valid_q    <= valid_d;
      victim_q   <= victim_d;
      drive_q    <= drive_d;
      spurious_q <= spurious_d;
      plru_q     <= plru_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (req_valid) state_d = ST_SETUP;
      ST_SETUP:     state_d = ST_DRIVE;
      ST_DRIVE:     state_d = ST_WAIT_FREE;
      ST_WAIT_FREE: if (free_rise) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Registered outputs and PLRU update
  always_comb begin
    set_d      = set_q;
    hit_d      = hit_q;
    hit_way_d  = hit_way_q;
    dirty_d    = dirty_q;
    valid_d    = valid_q;
    victim_d   = victim_q;
    drive_d    = 1'b0;
    plru_d     = plru_q;
    // A completion edge is only meaningful while waiting for one
    spurious_d = spurious_q | (free_rise && state_q != ST_WAIT_FREE);
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          set_d     = req_set;
          hit_d     = req_hit;
          hit_way_d = req_hit_way;
          dirty_d   = req_dirty;
        end
      end
      ST_SETUP: begin
        valid_d  = 3'b001 << sel_route;
        victim_d = sel_way;
      end
      // drive_q is registered so the pulse lands one edge after valid*
      ST_DRIVE: drive_d = 1'b1;
      ST_WAIT_FREE: begin
        if (free_rise) begin
          valid_d       = '0;
          plru_d[set_q] = plru_touch(plru_q[set_q], victim_q);
        end
      end
      default: ;
    endcase
  end

  assign req_ready    = (state_q == ST_IDLE);
  assign o_busy       = (state_q != ST_IDLE);
  assign valid0       = valid_q[0];
  assign valid1       = valid_q[1];
  assign valid2       = valid_q[2];
  assign o_victim_way = victim_q;
  assign o_drive      = drive_q;
  assign o_spurious   = spurious_q;

endmodule

// File: tb/tb_cache_route_decider.sv
// Randomized self-checking bench for cache_route_decider with a tree-PLRU
// reference model kept as plain per-set bit arrays.
module tb_cache_route_decider;

  localparam int SETS = 16;
  localparam int SYNC = 2;

  logic       clk, rst;
  logic       req_valid, req_ready;
  logic [3:0] req_set;
  logic       req_hit;
  logic [1:0] req_hit_way;
  logic [3:0] req_dirty;
  logic       valid0, valid1, valid2;
  logic [1:0] o_victim_way;
  logic       o_drive, i_free, o_busy, o_spurious;

  cache_route_decider #(.SETS(SETS), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_set(req_set), .req_hit(req_hit), .req_hit_way(req_hit_way),
    .req_dirty(req_dirty),
    .valid0(valid0), .valid1(valid1), .valid2(valid2),
    .o_victim_way(o_victim_way), .o_drive(o_drive),
    .i_free(i_free), .o_busy(o_busy), .o_spurious(o_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference model
  bit [2:0] m_plru [SETS];
  bit       m_spur;

  // launch monitor
  int cyc = 0;
  int drive_cnt = 0;
  int last_rise = -1;
  int min_gap = 1000;
  bit drive_prev = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (o_drive) drive_cnt <= drive_cnt + 1;
    if (o_drive && !drive_prev) begin
      if (last_rise >= 0 && (cyc - last_rise) < min_gap) min_gap <= cyc - last_rise;
      last_rise <= cyc;
    end
    drive_prev <= o_drive;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_victim(input int set);
    bit [2:0] b;
    b = m_plru[set];
    return b[0] ? 2 + int'(b[2]) : int'(b[1]);
  endfunction

  function automatic bit [2:0] ref_touch(input bit [2:0] b, input int way);
    bit [2:0] r;
    r = b;
    if (way < 2) begin r[0] = 1'b1; r[1] = (way == 0); end
    else         begin r[0] = 1'b0; r[2] = (way == 2); end
    return r;
  endfunction

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 1);
    chk({tag, "_valid"}, 32'({valid2, valid1, valid0}), 0);
    chk({tag, "_victim"}, 32'(o_victim_way), 0);
    chk({tag, "_drive"}, 32'(o_drive), 0);
    chk({tag, "_busy"}, 32'(o_busy), 0);
    chk({tag, "_spur"}, 32'(o_spurious), 0);
  endtask

  // One full transaction; hold keeps req_valid asserted throughout
  task automatic run_txn(input int set, input bit hit, input int way,
                         input logic [3:0] dirty, input int free_dly, input bit hold);
    int vic, route;
    logic [2:0] oh;
    vic   = hit ? way : ref_victim(set);
    route = hit ? 0 : (dirty[vic] ? 2 : 1);
    oh    = 3'(1 << route);
    @(negedge clk);
    req_valid = 1'b1; req_set = 4'(set); req_hit = hit;
    req_hit_way = 2'(way); req_dirty = dirty;
    @(posedge clk); #1;                                   // E0
    chk("e0_ready", 32'(req_ready), 0);
    chk("e0_busy", 32'(o_busy), 1);
    chk("e0_valid", 32'({valid2, valid1, valid0}), 0);
    if (!hold) req_valid = 1'b0;
    @(posedge clk); #1;                                   // E1
    chk("e1_valid", 32'({valid2, valid1, valid0}), 32'(oh));
    chk("e1_victim", 32'(o_victim_way), 32'(vic));
    chk("e1_drive", 32'(o_drive), 0);
    @(posedge clk); #1;                                   // E2
    chk("e2_drive", 32'(o_drive), 1);
    @(posedge clk); #1;                                   // E3
    chk("e3_drive", 32'(o_drive), 0);
    chk("e3_valid", 32'({valid2, valid1, valid0}), 32'(oh));
    repeat (free_dly) @(posedge clk);
    #1 chk("wait_ready", 32'(req_ready), 0);
    @(negedge clk); i_free = 1'b1;
    repeat (SYNC + 1) @(posedge clk); #1;                 // Ek
    chk("ek_ready", 32'(req_ready), 0);
    chk("ek_valid", 32'({valid2, valid1, valid0}), 32'(oh));
    @(posedge clk); #1;                                   // Ek+1
    m_plru[set] = ref_touch(m_plru[set], vic);
    chk("ek1_ready", 32'(req_ready), 1);
    chk("ek1_busy", 32'(o_busy), 0);
    chk("ek1_valid", 32'({valid2, valid1, valid0}), 0);
    chk("ek1_spur", 32'(o_spurious), 32'(m_spur));
    i_free = 1'b0;
  endtask

  initial begin
    int d0;
    rst = 1'b1; req_valid = 1'b0; req_set = '0; req_hit = 1'b0;
    req_hit_way = '0; req_dirty = '0; i_free = 1'b0; m_spur = 1'b0;
    foreach (m_plru[i]) m_plru[i] = 3'b000;
    repeat (2) @(posedge clk); #1;
    chk_reset_outs("reset");
    @(negedge clk); rst = 1'b0;

    // directed sequence
    run_txn(3, 0, 0, 4'b0000, 1, 0);   // clean miss, victim 0
    run_txn(3, 0, 0, 4'b0100, 0, 0);   // dirty miss, victim 2
    run_txn(5, 1, 1, 4'b1111, 2, 0);   // hit way 1
    run_txn(3, 0, 0, 4'b0000, 0, 0);   // set 3 unaffected by set 5

    // req_valid held across launches
    d0 = drive_cnt;
    run_txn(7, 0, 0, 4'b1010, 0, 1);
    run_txn(7, 0, 0, 4'b1010, 0, 1);
    run_txn(7, 1, 3, 4'b1010, 1, 1);
    req_valid = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("hold_drives", 32'(drive_cnt - d0), 3);
    chk("hold_idle_ready", 32'(req_ready), 1);

    // random traffic over a few sets to exercise PLRU reuse
    for (int n = 0; n < 40; n++)
      run_txn(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)), 4'($urandom), int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    req_valid = 1'b0;

    // i_free in IDLE: ignored by FSM, sticky spurious flag
    repeat (3) @(posedge clk);
    d0 = drive_cnt;
    @(negedge clk); i_free = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); i_free = 1'b0;
    repeat (4) @(posedge clk); #1;
    m_spur = 1'b1;
    chk("idle_free_drive", 32'(drive_cnt - d0), 0);
    chk("idle_free_ready", 32'(req_ready), 1);
    chk("idle_free_busy", 32'(o_busy), 0);
    chk("idle_free_spur", 32'(o_spurious), 1);
    run_txn(2, 0, 0, 4'b0001, 1, 0);   // spurious stays set

    // reset during WAIT_FREE
    @(negedge clk);
    req_valid = 1'b1; req_set = 4'd3; req_hit = 1'b0; req_dirty = 4'b0000;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("mid_busy", 32'(o_busy), 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_outs("mid_reset");
    @(negedge clk); rst = 1'b0;
    foreach (m_plru[i]) m_plru[i] = 3'b000;
    m_spur = 1'b0;
    i_free = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); i_free = 1'b0;
    repeat (4) @(posedge clk); #1;
    m_spur = 1'b1;
    chk("late_free_spur", 32'(o_spurious), 1);
    chk("late_free_ready", 32'(req_ready), 1);
    run_txn(3, 0, 0, 4'b0000, 0, 0);   // PLRU cleared: victim 0
    run_txn(3, 0, 0, 4'b0000, 0, 0);

    chk("min_launch_gap_ok", 32'(min_gap >= 4 + SYNC), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
